// File: rtl/trigger_capture_controller.sv
// Trigger-aligned capture sequencer for one ADC channel: writes samples into a
// circular buffer, keeps PRE_TRIG pre-trigger samples and freezes until a frame is shown.
module trigger_capture_controller #(
   parameter int unsigned DATA_W       = 10,
   parameter int unsigned DEPTH        = 640,
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned PRE_TRIG     = 320,
   parameter int unsigned AUTO_TIMEOUT = 1280
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_sample,
   input  logic [DATA_W-1:0] i_trig_level,
   input  logic              i_trig_rising,
   input  logic              i_single,
   input  logic              i_auto,
   input  logic              i_arm,
   input  logic              i_frame_done,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic [ADDR_W-1:0] o_start_addr,
   output logic              o_buffer_ready,
   output logic              o_triggered,
   output logic              o_auto_fired,
   output logic [2:0]        o_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PRE_FILL  = 3'd1,
      S_ARMED     = 3'd2,
      S_POST_FILL = 3'd3,
      S_HOLD      = 3'd4
   } state_e;

   localparam int unsigned PRE_W     = $clog2(PRE_TRIG + 1);
   localparam int unsigned TO_W      = $clog2(AUTO_TIMEOUT + 1);
   localparam int unsigned SUM_W     = ADDR_W + 1;
   localparam int unsigned POST_LOAD = DEPTH - PRE_TRIG - 1;
   localparam int unsigned START_OFS = DEPTH - PRE_TRIG;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
   logic [DATA_W-1:0]   prev_q, prev_d;
   logic                prev_valid_q, prev_valid_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
   logic                buf_ready_q, buf_ready_d;
   logic                triggered_q, triggered_d;
   logic                auto_fired_q, auto_fired_d;

   logic                writing;
   logic                rise_hit;
   logic                fall_hit;
   logic                real_trig;
   logic                auto_trig;
   logic                enter_pre;
   logic [SUM_W-1:0]    start_sum;
   logic [SUM_W-1:0]    start_mod;

   assign writing   = (state_q == S_PRE_FILL) || (state_q == S_ARMED) || (state_q == S_POST_FILL);
   assign rise_hit  = (prev_q < i_trig_level) && (i_sample >= i_trig_level);
   assign fall_hit  = (prev_q > i_trig_level) && (i_sample <= i_trig_level);
   assign real_trig = prev_valid_q && (i_trig_rising ? rise_hit : fall_hit);
   assign auto_trig = i_auto && (to_cnt_q >= TO_W'(AUTO_TIMEOUT - 1));

   // Oldest sample of the capture, computed one bit wider so the sum cannot overflow
   assign start_sum = SUM_W'(wr_ptr_q) + SUM_W'(START_OFS);
   assign start_mod = (start_sum >= SUM_W'(DEPTH)) ? (start_sum - SUM_W'(DEPTH)) : start_sum;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      pre_cnt_d    = pre_cnt_q;
      to_cnt_d     = to_cnt_q;
      post_cnt_d   = post_cnt_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      start_addr_d = start_addr_q;
      triggered_d  = 1'b0;
      auto_fired_d = auto_fired_q;
      enter_pre    = 1'b0;

      if (writing && i_sample_valid) begin
         wr_en_d      = 1'b1;
         wr_addr_d    = wr_ptr_q;
         wr_data_d    = i_sample;
         wr_ptr_d     = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : (wr_ptr_q + ADDR_W'(1));
         prev_d       = i_sample;
         prev_valid_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (!i_single || i_arm) begin
               state_d   = S_PRE_FILL;
               enter_pre = 1'b1;
            end
         end
         S_PRE_FILL: begin
            if (i_sample_valid) begin
               pre_cnt_d = pre_cnt_q + PRE_W'(1);
               if (pre_cnt_q == PRE_W'(PRE_TRIG - 1)) state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (i_sample_valid) begin
               if (real_trig || auto_trig) begin
                  start_addr_d = ADDR_W'(start_mod);
                  triggered_d  = 1'b1;
                  auto_fired_d = !real_trig;
                  post_cnt_d   = ADDR_W'(POST_LOAD);
                  state_d      = (POST_LOAD == 0) ? S_HOLD : S_POST_FILL;
               end else if (to_cnt_q < TO_W'(AUTO_TIMEOUT)) begin
                  to_cnt_d = to_cnt_q + TO_W'(1);
               end
            end
         end
         S_POST_FILL: begin
            // The write that takes post_cnt to zero completes the buffer
            if (i_sample_valid) begin
               post_cnt_d = post_cnt_q - ADDR_W'(1);
               if (post_cnt_q == ADDR_W'(1)) state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_frame_done) begin
               if (i_single) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_PRE_FILL;
                  enter_pre = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (enter_pre) begin
         pre_cnt_d    = '0;
         to_cnt_d     = '0;
         prev_valid_d = 1'b0;
      end

      buf_ready_d = (state_d == S_HOLD);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         pre_cnt_q    <= '0;
         to_cnt_q     <= '0;
         post_cnt_q   <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         start_addr_q <= '0;
         buf_ready_q  <= 1'b0;
         triggered_q  <= 1'b0;
         auto_fired_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         pre_cnt_q    <= pre_cnt_d;
         to_cnt_q     <= to_cnt_d;
         post_cnt_q   <= post_cnt_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         start_addr_q <= start_addr_d;
         buf_ready_q  <= buf_ready_d;
         triggered_q  <= triggered_d;
         auto_fired_q <= auto_fired_d;
      end
   end

   assign o_wr_en        = wr_en_q;
   assign o_wr_addr      = wr_addr_q;
   assign o_wr_data      = wr_data_q;
   assign o_start_addr   = start_addr_q;
   assign o_buffer_ready = buf_ready_q;
   assign o_triggered    = triggered_q;
   assign o_auto_fired   = auto_fired_q;
   assign o_state        = state_q;

endmodule

// File: tb/tb_trigger_capture_controller.sv
// Directed bench for trigger_capture_controller with DEPTH=16, PRE_TRIG=4, AUTO_TIMEOUT=8.
module tb_trigger_capture_controller;

   localparam int unsigned DATA_W = 10;
   localparam int unsigned ADDR_W = 4;
   localparam logic [1:0]  OP_S   = 2'd0;
   localparam logic [1:0]  OP_FD  = 2'd1;

   typedef struct {
      logic [1:0]        op;
      logic              rising;
      logic [DATA_W-1:0] sample;
      logic              e_en;
      logic [ADDR_W-1:0] e_addr;
      logic [2:0]        e_state;
      logic              e_trig;
      logic              e_ready;
      logic [ADDR_W-1:0] e_start;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic              sample_valid;
   logic [DATA_W-1:0] sample;
   logic [DATA_W-1:0] trig_level;
   logic              trig_rising;
   logic              single;
   logic              auto_en;
   logic              arm;
   logic              frame_done;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] start_addr;
   logic              buffer_ready;
   logic              triggered;
   logic              auto_fired;
   logic [2:0]        state;

   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   trigger_capture_controller #(
      .DATA_W      (DATA_W),
      .DEPTH       (16),
      .ADDR_W      (ADDR_W),
      .PRE_TRIG    (4),
      .AUTO_TIMEOUT(8)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_sample_valid(sample_valid),
      .i_sample      (sample),
      .i_trig_level  (trig_level),
      .i_trig_rising (trig_rising),
      .i_single      (single),
      .i_auto        (auto_en),
      .i_arm         (arm),
      .i_frame_done  (frame_done),
      .o_wr_en       (wr_en),
      .o_wr_addr     (wr_addr),
      .o_wr_data     (wr_data),
      .o_start_addr  (start_addr),
      .o_buffer_ready(buffer_ready),
      .o_triggered   (triggered),
      .o_auto_fired  (auto_fired),
      .o_state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"},      32'(wr_en),        0);
      chk({tag, "_wr_addr"},    32'(wr_addr),      0);
      chk({tag, "_wr_data"},    32'(wr_data),      0);
      chk({tag, "_start_addr"}, 32'(start_addr),   0);
      chk({tag, "_ready"},      32'(buffer_ready), 0);
      chk({tag, "_triggered"},  32'(triggered),    0);
      chk({tag, "_auto_fired"}, 32'(auto_fired),   0);
      chk({tag, "_state"},      32'(state),        0);
   endtask

   // One clock: inputs applied after the falling edge, outputs sampled 1 time unit after the rising edge
   task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] s, input logic fd, input logic a);
      @(negedge clk);
      sample_valid = v;
      sample       = s;
      frame_done   = fd;
      arm          = a;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      frame_done   = 1'b0;
      arm          = 1'b0;
   endtask

   task automatic smp(input string nm, input int val, input int e_addr, input int e_state);
      drive_cycle(1'b1, DATA_W'(val), 1'b0, 1'b0);
      chk({nm, "_we"},    32'(wr_en),   1);
      chk({nm, "_addr"},  32'(wr_addr), e_addr);
      chk({nm, "_data"},  32'(wr_data), val);
      chk({nm, "_state"}, 32'(state),   e_state);
   endtask

   function automatic void add(input logic [1:0] op, input logic r, input int s, input logic en,
                               input int a, input int st, input logic tg, input logic rdy, input int sa);
      vec_t v;
      v.op      = op;
      v.rising  = r;
      v.sample  = DATA_W'(s);
      v.e_en    = en;
      v.e_addr  = ADDR_W'(a);
      v.e_state = 3'(st);
      v.e_trig  = tg;
      v.e_ready = rdy;
      v.e_start = ADDR_W'(sa);
      vecs.push_back(v);
   endfunction

   initial begin
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      sample       = '0;
      trig_level   = DATA_W'(100);
      trig_rising  = 1'b1;
      single       = 1'b0;
      auto_en      = 1'b0;
      arm          = 1'b0;
      frame_done   = 1'b0;

      #2;
      chk_zero("reset");
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_to_prefill", 32'(state), 1);

      // Rising ramp, trigger on 100 at address 5
      for (int i = 0; i < 4; i++) add(OP_S, 1'b1, 20 * i, 1'b1, i, (i == 3) ? 2 : 1, 1'b0, 1'b0, 0);
      add(OP_S, 1'b1, 80, 1'b1, 4, 2, 1'b0, 1'b0, 0);
      add(OP_S, 1'b1, 100, 1'b1, 5, 3, 1'b1, 1'b0, 1);
      for (int k = 0; k < 11; k++)
         add(OP_S, 1'b1, 120 + 20 * k, 1'b1, (6 + k) % 16, (k == 10) ? 4 : 3, 1'b0, k == 10, 1);
      add(OP_S,  1'b1, 500, 1'b0, 0, 4, 1'b0, 1'b1, 1);
      add(OP_FD, 1'b1, 0,   1'b0, 0, 1, 1'b0, 1'b0, 1);
      // Falling ramp with a flat 100 stretch, trigger on 100 after 140
      add(OP_S, 1'b0, 200, 1'b1, 1, 1, 1'b0, 1'b0, 1);
      add(OP_S, 1'b0, 180, 1'b1, 2, 1, 1'b0, 1'b0, 1);
      add(OP_S, 1'b0, 160, 1'b1, 3, 1, 1'b0, 1'b0, 1);
      add(OP_S, 1'b0, 100, 1'b1, 4, 2, 1'b0, 1'b0, 1);
      for (int i = 0; i < 3; i++) add(OP_S, 1'b0, 100, 1'b1, 5 + i, 2, 1'b0, 1'b0, 1);
      add(OP_S, 1'b0, 140, 1'b1, 8, 2, 1'b0, 1'b0, 1);
      add(OP_S, 1'b0, 100, 1'b1, 9, 3, 1'b1, 1'b0, 5);
      for (int k = 0; k < 11; k++)
         add(OP_S, 1'b0, 50, 1'b1, (10 + k) % 16, (k == 10) ? 4 : 3, 1'b0, k == 10, 5);
      add(OP_FD, 1'b0, 0, 1'b0, 0, 1, 1'b0, 1'b0, 5);

      foreach (vecs[i]) begin
         trig_rising = vecs[i].rising;
         drive_cycle(vecs[i].op == OP_S, vecs[i].sample, vecs[i].op == OP_FD, 1'b0);
         chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_en));
         if (vecs[i].e_en) begin
            chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].sample));
         end
         chk($sformatf("vec%0d_state", i),      32'(state),        32'(vecs[i].e_state));
         chk($sformatf("vec%0d_triggered", i),  32'(triggered),    32'(vecs[i].e_trig));
         chk($sformatf("vec%0d_ready", i),      32'(buffer_ready), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d_start", i),      32'(start_addr),   32'(vecs[i].e_start));
         chk($sformatf("vec%0d_auto", i),       32'(auto_fired),   0);
         drive_cycle(1'b0, '0, 1'b0, 1'b0);
         chk($sformatf("vec%0d_idle_we", i),    32'(wr_en),        0);
         chk($sformatf("vec%0d_idle_trig", i),  32'(triggered),    0);
         drive_cycle(1'b0, '0, 1'b0, 1'b0);
      end

      // Auto timeout: flat 50, forced trigger on the 8th ARMED sample (address 0)
      trig_rising = 1'b1;
      auto_en     = 1'b1;
      for (int i = 0; i < 4; i++) smp($sformatf("auto_pre%0d", i), 50, 5 + i, (i == 3) ? 2 : 1);
      for (int i = 1; i < 8; i++) begin
         smp($sformatf("auto_arm%0d", i), 50, 8 + i, 2);
         chk($sformatf("auto_arm%0d_trig", i), 32'(triggered), 0);
      end
      smp("auto_fire", 50, 0, 3);
      chk("auto_fire_trig",  32'(triggered),  1);
      chk("auto_fire_flag",  32'(auto_fired), 1);
      chk("auto_fire_start", 32'(start_addr), 12);
      for (int i = 1; i <= 11; i++) smp($sformatf("auto_post%0d", i), 50, i, (i == 11) ? 4 : 3);
      chk("auto_hold_ready", 32'(buffer_ready), 1);
      chk("auto_hold_flag",  32'(auto_fired),   1);
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      chk("auto_exit_state", 32'(state), 1);

      // No auto: ARMED persists past the timeout, i_arm ignored, then a real trigger at address 2
      auto_en = 1'b0;
      for (int i = 0; i < 4; i++) smp($sformatf("wrap_pre%0d", i), 50, 12 + i, (i == 3) ? 2 : 1);
      for (int i = 0; i < 18; i++) begin
         drive_cycle(1'b1, DATA_W'(50), 1'b0, i == 5);
         chk($sformatf("wrap_arm%0d_addr", i),  32'(wr_addr),   i % 16);
         chk($sformatf("wrap_arm%0d_state", i), 32'(state),     2);
         chk($sformatf("wrap_arm%0d_trig", i),  32'(triggered), 0);
      end
      chk("wrap_noauto_flag", 32'(auto_fired), 1);
      smp("wrap_trig", 150, 2, 3);
      chk("wrap_trig_pulse", 32'(triggered),  1);
      chk("wrap_trig_start", 32'(start_addr), 14);
      chk("wrap_trig_flag",  32'(auto_fired), 0);
      for (int i = 1; i <= 11; i++) smp($sformatf("wrap_post%0d", i), 200, 2 + i, (i == 11) ? 4 : 3);

      // Single mode: no writes in HOLD, frame_done to IDLE, wait for arm
      single = 1'b1;
      drive_cycle(1'b1, DATA_W'(77), 1'b0, 1'b0);
      chk("hold_we",    32'(wr_en), 0);
      chk("hold_state", 32'(state), 4);
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      chk("single_idle_state", 32'(state),        0);
      chk("single_idle_ready", 32'(buffer_ready), 0);
      repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
      chk("single_wait_state", 32'(state), 0);
      drive_cycle(1'b1, DATA_W'(55), 1'b0, 1'b0);
      chk("idle_we",    32'(wr_en), 0);
      chk("idle_state", 32'(state), 0);
      drive_cycle(1'b0, '0, 1'b0, 1'b1);
      chk("arm_state", 32'(state), 1);

      // Reset in the middle of POST_FILL
      single = 1'b0;
      for (int i = 0; i < 4; i++) smp($sformatf("rst_pre%0d", i), 50, (14 + i) % 16, (i == 3) ? 2 : 1);
      smp("rst_trig", 150, 2, 3);
      smp("rst_post1", 60, 3, 3);
      smp("rst_post2", 70, 4, 3);
      @(negedge clk);
      sample_valid = 1'b1;
      sample       = DATA_W'(9);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      @(posedge clk);
      #1;
      chk("rst_held_we",    32'(wr_en), 0);
      chk("rst_held_state", 32'(state), 0);
      @(negedge clk);
      sample_valid = 1'b0;
      rst_n        = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_restart_state", 32'(state), 1);
      smp("rst_first", 33, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
